// File: rtl/xor_parity_pkg.sv
// xor_parity_pkg
// Shared definitions for the parity-checking serial receiver:
//   - rx_state_t     : receiver FSM states
//   - DEFAULT_DATA_W : default number of data bits per frame
//   - cnt_width()    : width of the data-bit counter for a given frame width
package xor_parity_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // The counter only has to index bits 0..w-1; keep at least one bit so
    // a 1-bit frame still has a legal vector.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/xor_parity_shift.sv
// xor_parity_shift
// Data-bit capture for one frame: shift register, bit counter and running
// XOR of all captured bits.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   clear   : start of frame; zero register, counter and XOR
//   load    : capture sample into data[count] and advance the counter
//   sample  : serial bit being captured
//   data    : captured word, first bit received in bit 0
//   xor_acc : XOR of every bit captured since the last clear
//   last    : the next load captures the final data bit of the frame
module xor_parity_shift
    import xor_parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              sample,
    output logic [DATA_W-1:0] data,
    output logic              xor_acc,
    output logic              last
);

    localparam int CNT_W = cnt_width(DATA_W);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            count   <= '0;
            xor_acc <= 1'b0;
        end else if (clear) begin
            data    <= '0;
            count   <= '0;
            xor_acc <= 1'b0;
        end else if (load) begin
            data[count] <= sample;
            count       <= count + CNT_W'(1);
            xor_acc     <= xor_acc ^ sample;
        end
    end

    assign last = (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/xor_parity_rx.sv
// xor_parity_rx
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one
// parity bit, one stop bit (1). The line is sampled only when rx_en=1.
// A completed frame is presented on a valid/ready output port.
// Optional statistics counters are built when XOR_PARITY_RX_STATS_EN is
// defined.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   rx_en, rx_bit       : bit strobe and serial line (idles at 1)
//   out_data            : received word
//   out_valid/out_ready : output handshake
//   out_perr, out_ferr  : parity error / framing error of the held word
//   overrun             : one-cycle pulse when a completed frame is dropped
//   busy                : receiver is inside a frame
//   dbg_state           : current FSM state, for observation only
//   frame_cnt, err_cnt  : (XOR_PARITY_RX_STATS_EN only) completed frames and
//                         frames with a parity or framing error
//
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1. Once raised, out_valid stays high and out_data/out_perr/
// out_ferr stay stable until that transfer; out_valid never depends on
// out_ready combinationally.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              overrun,
    output logic              busy,
`ifdef XOR_PARITY_RX_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt,
`endif
    output rx_state_t         dbg_state
);

    localparam logic ODD_BIT = (ODD_PARITY != 0);

    rx_state_t         state_q, state_d;
    logic              shift_clear, shift_load, complete;
    logic [DATA_W-1:0] shift_data;
    logic              xor_acc, last;
    logic              perr_q;
    logic              ferr_new;

    xor_parity_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (shift_clear),
        .load    (shift_load),
        .sample  (rx_bit),
        .data    (shift_data),
        .xor_acc (xor_acc),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_clear = 1'b0;
        shift_load  = 1'b0;
        complete    = 1'b0;
        if (rx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d     = ST_DATA;
                        shift_clear = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_load = 1'b1;
                    if (last) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The stop sample itself decides the framing error, so it is used
    // directly at completion rather than registered first.
    assign ferr_new = ~rx_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (rx_en && (state_q == ST_PARITY)) begin
            perr_q <= xor_acc ^ rx_bit ^ ODD_BIT;
        end
    end

    // Output holding register. A completion is accepted when the slot is
    // empty or is being emptied in the same cycle; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            out_ferr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shift_data;
                    out_perr  <= perr_q;
                    out_ferr  <= ferr_new;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef XOR_PARITY_RX_STATS_EN
    // Dropped frames still count: these describe the line, not the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (complete) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (perr_q || ferr_new) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xor_parity_rx.sv
module tb_xor_parity_rx;
    import xor_parity_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset / DUT signals ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_en = 1'b0;
    logic         rx_bit = 1'b1;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data, odd_data;
    logic         out_valid, out_perr, out_ferr, overrun, busy;
    logic         odd_valid, odd_perr, odd_ferr, odd_overrun, odd_busy;
    rx_state_t    dbg_state, odd_dbg_state;
`ifdef XOR_PARITY_RX_STATS_EN
    logic [15:0]  frame_cnt, err_cnt, odd_frame_cnt, odd_err_cnt;
`endif

    always #5 clk = ~clk;

    xor_parity_rx #(.DATA_W(W), .ODD_PARITY(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .rx_bit    (rx_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perr  (out_perr),
        .out_ferr  (out_ferr),
        .overrun   (overrun),
        .busy      (busy),
`ifdef XOR_PARITY_RX_STATS_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .dbg_state (dbg_state)
    );

    xor_parity_rx #(.DATA_W(W), .ODD_PARITY(1)) dut_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .rx_bit    (rx_bit),
        .out_data  (odd_data),
        .out_valid (odd_valid),
        .out_ready (out_ready),
        .out_perr  (odd_perr),
        .out_ferr  (odd_ferr),
        .overrun   (odd_overrun),
        .busy      (odd_busy),
`ifdef XOR_PARITY_RX_STATS_EN
        .frame_cnt (odd_frame_cnt),
        .err_cnt   (odd_err_cnt),
`endif
        .dbg_state (odd_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_fail = 0;
    int ovr_cycles = 0;
    int exp_drops = 0;
    int mdl_frames = 0;
    int mdl_errs = 0;

    // Counts every cycle overrun is high; must equal the number of drops.
    always @(negedge clk) begin
        if (overrun) ovr_cycles++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int gap_max);
        int n;
        n = $urandom_range(gap_max, 0);
        repeat (n) begin
            rx_en  = 1'b0;
            rx_bit = 1'($urandom_range(1, 0));
            tick();
        end
    endtask

    task automatic send_bit(input logic b, input int gap_max);
        idle_gap(gap_max);
        rx_en  = 1'b1;
        rx_bit = b;
        tick();
        rx_en  = 1'b0;
        rx_bit = 1'b1;
    endtask

    // Data, parity and stop bits. rdy_stop raises out_ready only for the
    // cycle that samples the stop bit.
    task automatic send_body(input logic [W-1:0] d, input logic pbit, input logic stop,
                             input int gap_max, input logic rdy_stop);
        for (int i = 0; i < W; i++) send_bit(d[i], gap_max);
        send_bit(pbit, gap_max);
        idle_gap(gap_max);
        if (rdy_stop) out_ready = 1'b1;
        rx_en  = 1'b1;
        rx_bit = stop;
        tick();
        rx_en  = 1'b0;
        rx_bit = 1'b1;
        if (rdy_stop) out_ready = 1'b0;
        mdl_frames++;
        if (((^d) ^ pbit) || !stop) mdl_errs++;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic stop,
                              input int gap_max, input logic rdy_stop);
        send_bit(1'b0, gap_max);
        send_body(d, pbit, stop, gap_max, rdy_stop);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         pbit;
        logic         stop;
        logic         exp_perr;
        logic         exp_ferr;
        logic         exp_perr_odd;
    } vec_t;

    vec_t vecs[8];

    // ---------------- random-phase scoreboard ----------------
    // Entry: {odd perr, even perr, ferr, data}
    logic [W+2:0] exp_q[$];
    logic         held;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_perr", out_perr, 0);
        check("rst_ferr", out_ferr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single frames with random rx_en gaps
        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].pbit, vecs[k].stop, 2, 1'b0);
            check("tbl_valid", out_valid, 1);
            check("tbl_data", out_data, vecs[k].data);
            check("tbl_perr", out_perr, vecs[k].exp_perr);
            check("tbl_ferr", out_ferr, vecs[k].exp_ferr);
            check("tbl_perr_odd", odd_perr, vecs[k].exp_perr_odd);
            check("tbl_overrun", overrun, 0);
            check("tbl_busy", busy, 0);
            consume();
            check("tbl_valid_after_ack", out_valid, 0);
        end

        // Overrun: second frame dropped while first is held
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        check("ovr_first_data", out_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        exp_drops++;
        check("ovr_pulse", overrun, 1);
        check("ovr_held_data", out_data, 8'h11);
        check("ovr_held_valid", out_valid, 1);
        tick();
        check("ovr_pulse_end", overrun, 0);
        check("ovr_held_data2", out_data, 8'h11);

        // Completion coincides with handshake: new word loads, valid stays
        send_frame(8'h44, 1'b0, 1'b1, 0, 1'b1);
        check("coinc_valid", out_valid, 1);
        check("coinc_data", out_data, 8'h44);
        check("coinc_overrun", overrun, 0);

        // Start bit accepted in the handshake cycle
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        out_ready = 1'b0;
        check("start_ack_valid", out_valid, 0);
        check("start_ack_busy", busy, 1);
        send_body(8'h55, 1'b0, 1'b1, 0, 1'b0);
        check("start_ack_data", out_data, 8'h55);
        check("start_ack_ovr", overrun, 0);

        // Reset mid-frame (word 0x55 still held)
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1, 0)), 0);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mdl_frames = 0;
        mdl_errs = 0;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_perr", out_perr, 0);
        check("midrst_ferr", out_ferr, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        tick();
        check("midrst_no_output", out_valid, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
        check("post_rst_data", out_data, 8'h5A);
        check("post_rst_perr", out_perr, 0);
        consume();

        // Three good frames plus one parity error since reset
        send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0);
        consume();
        send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
        consume();
        send_frame(8'h12, 1'b1, 1'b1, 0, 1'b0);
        check("stats_perr_frame", out_perr, 1);
        consume();
`ifdef XOR_PARITY_RX_STATS_EN
        check("stats_frame_cnt4", frame_cnt, 4);
        check("stats_err_cnt1", err_cnt, 1);
`endif

        // Randomized frames against the reference model
        held = 1'b0;
        exp_q.delete();
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] d;
            logic         pbit, stop, rdy, drop, pe;
            d    = W'($urandom);
            pbit = 1'($urandom_range(1, 0));
            stop = ($urandom_range(3, 0) != 0);
            rdy  = 1'($urandom_range(1, 0));
            send_frame(d, pbit, stop, 2, rdy);
            pe   = (^d) ^ pbit;
            drop = held && !rdy;
            if (!drop) begin
                if (held) void'(exp_q.pop_front());
                exp_q.push_back({~pe, pe, ~stop, d});
                held = 1'b1;
            end else begin
                exp_drops++;
            end
            check("rnd_overrun", overrun, drop);
            check("rnd_valid", out_valid, 1);
            check("rnd_data", out_data, exp_q[$][W-1:0]);
            check("rnd_ferr", out_ferr, exp_q[$][W]);
            check("rnd_perr", out_perr, exp_q[$][W+1]);
            check("rnd_perr_odd", odd_perr, exp_q[$][W+2]);
            check("rnd_odd_data", odd_data, exp_q[$][W-1:0]);
            if ($urandom_range(1, 0) == 1) begin
                consume();
                void'(exp_q.pop_front());
                held = 1'b0;
                check("rnd_valid_after_ack", out_valid, 0);
            end
        end

        repeat (2) tick();
        check("overrun_cycles", ovr_cycles, exp_drops);
`ifdef XOR_PARITY_RX_STATS_EN
        check("final_frame_cnt", frame_cnt, mdl_frames);
        check("final_err_cnt", err_cnt, mdl_errs);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
